// File: rtl/instr_encoder.sv
// MIPS32 instruction encoder feeding an in-order FIFO that drains into the instruction-memory write port.
// Optional feature: define ENC_ILLEGAL_CHECK_EN to drop illegal ops and raise a sticky err_illegal.
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_rd,
  input  logic [15:0]              in_imm,
  input  logic [25:0]              in_target,
  input  logic                     addr_clear,
  output logic                     imem_we,
  input  logic                     imem_ready,
  output logic [ADDR_W-1:0]        imem_addr,
  output logic [31:0]              imem_wdata,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     err_illegal
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]    LVL_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]    LVL_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_LW   = 4'd5,
    OP_SW   = 4'd6,
    OP_BEQ  = 4'd7,
    OP_ADDI = 4'd8,
    OP_J    = 4'd9
  } op_e;

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [31:0]      enc_word;
  logic             illegal;
  logic             accept, push, pop, full, empty;

  always_comb begin
    enc_word = '0;
    illegal  = 1'b0;
    case (in_op)
      OP_ADD:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h20};
      OP_SUB:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h22};
      OP_AND:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h24};
      OP_OR:   enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h25};
      OP_SLT:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h2A};
      OP_LW:   enc_word = {6'h23, in_rs, in_rt, in_imm};
      OP_SW:   enc_word = {6'h2B, in_rs, in_rt, in_imm};
      OP_BEQ:  enc_word = {6'h04, in_rs, in_rt, in_imm};
      OP_ADDI: enc_word = {6'h08, in_rs, in_rt, in_imm};
      OP_J:    enc_word = {6'h02, in_target};
      default: illegal  = 1'b1;
    endcase
  end

  assign full     = (count == LVL_FULL);
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign imem_we  = !empty;
  assign accept   = in_valid && in_ready;
  assign pop      = imem_we && imem_ready;

`ifdef ENC_ILLEGAL_CHECK_EN
  assign push = accept && !illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_illegal <= 1'b0;
    else if (accept && illegal)
      err_illegal <= 1'b1;
  end
`else
  // Illegal ops fall through the decoder with enc_word = 0, i.e. a NOP.
  assign push        = accept;
  assign err_illegal = 1'b0;
`endif

  // Storage carries no reset: the empty flag masks stale contents on imem_wdata.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= enc_word;
  end

  assign imem_wdata = empty ? '0 : mem[rd_ptr];
  assign fifo_level = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: count <= count;
      endcase
    end
  end

  // Clear takes priority over the post-write increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      imem_addr <= '0;
    else if (addr_clear)
      imem_addr <= '0;
    else if (pop)
      imem_addr <= imem_addr + ADDR_ONE;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder with hand-computed instruction words.
// Build with or without ENC_ILLEGAL_CHECK_EN; illegal-op expectations follow the macro.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        addr_clear;
  logic        imem_we;
  logic        imem_ready;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [2:0]  fifo_level;
  logic        err_illegal;

  int unsigned errors = 0;
  int unsigned checks = 0;

  instr_encoder #(.DEPTH(4), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_target(in_target),
    .addr_clear(addr_clear),
    .imem_we(imem_we), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .fifo_level(fifo_level), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
  endtask

  task automatic push_one(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    set_op(op, rs, rt, rd, imm, tgt);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain_one(input string tag, input logic [31:0] word, input logic [7:0] addr);
    check({tag, "_we"}, 32'(imem_we), 32'h1);
    check({tag, "_addr"}, 32'(imem_addr), 32'(addr));
    check({tag, "_data"}, imem_wdata, word);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; addr_clear = 1'b0; imem_ready = 1'b0;
    set_op(4'd0, '0, '0, '0, '0, '0);
    #12;
    check("rst_level", 32'(fifo_level), 32'h0);
    check("rst_we",    32'(imem_we),    32'h0);
    check("rst_addr",  32'(imem_addr),  32'h0);
    check("rst_wdata", imem_wdata,      32'h0);
    check("rst_ready", 32'(in_ready),   32'h1);
    check("rst_err",   32'(err_illegal), 32'h0);
    rst_n = 1'b1;
    tick();

    // ADD rs=1 rt=2 rd=3, unrelated imm/target set to prove they are ignored
    push_one(4'd0, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h3FFFFFF);
    check("add_level", 32'(fifo_level), 32'h1);
    drain_one("add", 32'h00221820, 8'd0);
    check("add_addr_inc", 32'(imem_addr), 32'h1);
    check("add_we_off",   32'(imem_we),   32'h0);

    // LW then J back to back with memory always ready: one word per cycle
    imem_ready = 1'b1;
    set_op(4'd5, 5'd0, 5'd8, 5'd31, 16'h0004, 26'h0);
    in_valid = 1'b1;
    tick();
    check("lw_we",   32'(imem_we),   32'h1);
    check("lw_addr", 32'(imem_addr), 32'h1);
    check("lw_data", imem_wdata,     32'h8C080004);
    set_op(4'd9, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h0000010);
    tick();
    in_valid = 1'b0;
    check("j_we",    32'(imem_we),   32'h1);
    check("j_addr",  32'(imem_addr), 32'h2);
    check("j_data",  imem_wdata,     32'h08000010);
    check("j_level", 32'(fifo_level), 32'h1);
    tick();
    imem_ready = 1'b0;
    check("lwj_done_addr", 32'(imem_addr), 32'h3);
    check("lwj_done_we",   32'(imem_we),   32'h0);

    // Fill the FIFO with imem_ready low
    push_one(4'd1, 5'd4,  5'd5,  5'd6,  16'h0, 26'h0);
    push_one(4'd2, 5'd7,  5'd8,  5'd9,  16'h0, 26'h0);
    push_one(4'd3, 5'd10, 5'd11, 5'd12, 16'h0, 26'h0);
    check("fill3_ready", 32'(in_ready), 32'h1);
    push_one(4'd4, 5'd13, 5'd14, 5'd15, 16'h0, 26'h0);
    check("full_level", 32'(fifo_level), 32'h4);
    check("full_ready", 32'(in_ready),   32'h0);
    set_op(4'd6, 5'd29, 5'd31, 5'd0, 16'hFFFC, 26'h0);
    in_valid = 1'b1;
    tick();
    check("full_hold_level", 32'(fifo_level), 32'h4);
    check("full_head", imem_wdata, 32'h00853022);
    check("full_head_addr", 32'(imem_addr), 32'h3);
    // Pop while full: the pending push must wait one cycle
    imem_ready = 1'b1;
    tick();
    check("pop_full_level", 32'(fifo_level), 32'h3);
    check("pop_full_ready", 32'(in_ready),   32'h1);
    check("pop_full_addr",  32'(imem_addr),  32'h4);
    check("pop_full_data",  imem_wdata,      32'h00E84824);
    tick();
    in_valid = 1'b0;
    imem_ready = 1'b0;
    check("pushpop_level", 32'(fifo_level), 32'h3);
    drain_one("or",  32'h014B6025, 8'd5);
    drain_one("slt", 32'h01AE782A, 8'd6);
    drain_one("sw",  32'hAFBFFFFC, 8'd7);
    check("fill_empty", 32'(fifo_level), 32'h0);

    // Address wrap: clear, stream 255 words, then one more write at 255
    addr_clear = 1'b1;
    tick();
    addr_clear = 1'b0;
    check("clr_idle_addr", 32'(imem_addr), 32'h0);
    set_op(4'd0, '0, '0, '0, '0, '0);
    imem_ready = 1'b1;
    in_valid = 1'b1;
    for (int unsigned i = 0; i < 255; i++) tick();
    in_valid = 1'b0;
    for (int unsigned i = 0; i < 8 && imem_we; i++) tick();
    imem_ready = 1'b0;
    check("stream_empty", 32'(fifo_level), 32'h0);
    check("stream_addr",  32'(imem_addr),  32'd255);
    push_one(4'd7, 5'd1, 5'd2, 5'd30, 16'h0003, 26'h0);
    drain_one("beq_wrap", 32'h10220003, 8'd255);
    check("wrap_addr", 32'(imem_addr), 32'h0);

    // addr_clear coincident with a write at address 5
    for (int unsigned i = 0; i < 5; i++) begin
      push_one(4'd0, '0, '0, '0, '0, '0);
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
    end
    push_one(4'd8, 5'd2, 5'd3, 5'd9, 16'h8001, 26'h0);
    check("clr_we",   32'(imem_we),   32'h1);
    check("clr_addr", 32'(imem_addr), 32'h5);
    check("clr_data", imem_wdata,     32'h20438001);
    addr_clear = 1'b1;
    imem_ready = 1'b1;
    tick();
    addr_clear = 1'b0;
    imem_ready = 1'b0;
    check("clr_next_addr", 32'(imem_addr),  32'h0);
    check("clr_level",     32'(fifo_level), 32'h0);

    // Illegal op 12
    push_one(4'd12, 5'd3, 5'd4, 5'd5, 16'hABCD, 26'h1234567);
`ifdef ENC_ILLEGAL_CHECK_EN
    check("ill_err",   32'(err_illegal), 32'h1);
    check("ill_level", 32'(fifo_level),  32'h0);
    check("ill_we",    32'(imem_we),     32'h0);
    tick();
    check("ill_sticky", 32'(err_illegal), 32'h1);
`else
    check("ill_err",   32'(err_illegal), 32'h0);
    check("ill_level", 32'(fifo_level),  32'h1);
    drain_one("ill_nop", 32'h00000000, 8'd0);
`endif

    // Asynchronous reset with three words queued
    push_one(4'd0, 5'd1, 5'd1, 5'd1, '0, '0);
    push_one(4'd1, 5'd2, 5'd2, 5'd2, '0, '0);
    push_one(4'd2, 5'd3, 5'd3, 5'd3, '0, '0);
    check("pre_rst_level", 32'(fifo_level), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_level", 32'(fifo_level),  32'h0);
    check("arst_we",    32'(imem_we),     32'h0);
    check("arst_addr",  32'(imem_addr),   32'h0);
    check("arst_wdata", imem_wdata,       32'h0);
    check("arst_ready", 32'(in_ready),    32'h1);
    check("arst_err",   32'(err_illegal), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    push_one(4'd4, 5'd13, 5'd14, 5'd15, '0, '0);
    drain_one("post_rst", 32'h01AE782A, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
